press_classify: RTL and testbench

//  Downstream consumer of the debounce filter's clean level output. Classifies each
//  key press as short, long or double and emits one-clock event pulses to the

---
 rtl/press_classify.sv | 145 ++++++++++++++
 tb/tb_press_classify.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/press_classify.sv
// Key-press classifier: turns the debounced key level into short / long / double
// press pulses. Define PRESS_CLASSIFY_REPEAT_EN to add auto-repeat pulses while long-held.
module press_classify #(
  parameter int CW         = 8,
  parameter int LONG_TICKS = 50,
  parameter int DBL_TICKS  = 20,
  parameter int REP_TICKS  = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic i,
  output logic short_p,
  output logic long_p,
  output logic dbl_p,
  output logic rep_p,
  output logic held,
  output logic busy
);

  // Handshake-free block: i is a level, sampled on en ticks; every output is a
  // registered level or a one-clk pulse following the deciding en tick.

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    PRESS1 = 3'd1,
    WAIT2  = 3'd2,
    PRESS2 = 3'd3,
    LONG   = 3'd4
  } state_t;

  localparam logic [CW-1:0] LONG_LAST = CW'(LONG_TICKS - 1);
  localparam logic [CW-1:0] DBL_LAST  = CW'(DBL_TICKS - 1);
  localparam logic [CW-1:0] REP_LAST  = CW'(REP_TICKS - 1);
  localparam logic [CW-1:0] CNT_MAX   = '1;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n, cnt_inc;
  logic          short_n, long_n, dbl_n, rep_n;

  assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + CW'(1);

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    short_n = 1'b0;
    long_n  = 1'b0;
    dbl_n   = 1'b0;
    rep_n   = 1'b0;
    case (state)
      IDLE: begin
        if (en && i) state_n = PRESS1;
      end
      PRESS1: begin
        if (en) begin
          if (!i) begin
            state_n = WAIT2;
          end else if (cnt == LONG_LAST) begin
            state_n = LONG;
            long_n  = 1'b1;
          end else begin
            cnt_n = cnt_inc;
          end
        end
      end
      WAIT2: begin
        if (en) begin
          if (i) begin
            state_n = PRESS2;
          end else if (cnt == DBL_LAST) begin
            state_n = IDLE;
            short_n = 1'b1;
          end else begin
            cnt_n = cnt_inc;
          end
        end
      end
      PRESS2: begin
        // A second press that goes long still reports the first press as short.
        if (en) begin
          if (!i) begin
            state_n = IDLE;
            dbl_n   = 1'b1;
          end else if (cnt == LONG_LAST) begin
            state_n = LONG;
            short_n = 1'b1;
            long_n  = 1'b1;
          end else begin
            cnt_n = cnt_inc;
          end
        end
      end
      LONG: begin
        if (en) begin
          if (!i) begin
            state_n = IDLE;
          end
`ifdef PRESS_CLASSIFY_REPEAT_EN
          else if (cnt == REP_LAST) begin
            rep_n = 1'b1;
            cnt_n = '0;
          end else begin
            cnt_n = cnt_inc;
          end
`endif
        end
      end
      default: state_n = IDLE;
    endcase
    if (state_n != state) cnt_n = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      short_p <= 1'b0;
      long_p  <= 1'b0;
      dbl_p   <= 1'b0;
      held    <= 1'b0;
      busy    <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      short_p <= short_n;
      long_p  <= long_n;
      dbl_p   <= dbl_n;
      held    <= (state_n == LONG);
      busy    <= (state_n != IDLE);
    end
  end

`ifdef PRESS_CLASSIFY_REPEAT_EN
  always_ff @(posedge clk) begin
    if (rst) rep_p <= 1'b0;
    else     rep_p <= rep_n;
  end
`else
  // Without auto-repeat the repeat period has no consumer.
  logic unused_rep;
  assign unused_rep = ^{REP_LAST, rep_n};
  assign rep_p      = 1'b0;
`endif

endmodule

// File: tb/tb_press_classify.sv
// Bench for press_classify: directed scenarios plus randomized key traffic, all
// checked every clock against a run-length model of press classification.
module tb_press_classify;

  localparam int CW = 8;
  localparam int LT = 5;
  localparam int DT = 3;
  localparam int RT = 2;
`ifdef PRESS_CLASSIFY_REPEAT_EN
  localparam bit REP_ON = 1'b1;
`else
  localparam bit REP_ON = 1'b0;
`endif

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en  = 1'b0;
  logic i   = 1'b0;
  logic short_p, long_p, dbl_p, rep_p, held, busy;

  always #5 clk = ~clk;

  press_classify #(.CW(CW), .LONG_TICKS(LT), .DBL_TICKS(DT), .REP_TICKS(RT)) dut (
    .clk(clk), .rst(rst), .en(en), .i(i),
    .short_p(short_p), .long_p(long_p), .dbl_p(dbl_p), .rep_p(rep_p),
    .held(held), .busy(busy)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  // Reference model: an episode is the list of run lengths of sampled levels,
  // starting with the first high sample seen while idle.
  bit m_active = 1'b0;
  int runs[$];
  bit e_short, e_long, e_dbl, e_rep, e_held, e_busy;

  // DUT pulse tallies for per-scenario totals
  int t_short, t_long, t_dbl, t_rep;

  task automatic end_episode();
    m_active = 1'b0;
    runs.delete();
  endtask

  task automatic model_edge(input bit r, input bit e, input bit iv);
    int n;
    int len;
    bit lvl;
    e_short = 1'b0;
    e_long  = 1'b0;
    e_dbl   = 1'b0;
    e_rep   = 1'b0;
    if (r) begin
      end_episode();
      e_held = 1'b0;
      e_busy = 1'b0;
      return;
    end
    if (!e) return;
    if (!m_active) begin
      if (iv) begin
        m_active = 1'b1;
        runs.push_back(1);
      end
    end else begin
      lvl = (runs.size() % 2 == 1);
      if (iv == lvl) runs[runs.size()-1] = runs[runs.size()-1] + 1;
      else runs.push_back(1);
      n   = runs.size();
      len = runs[n-1];
      case (n)
        1, 3: begin
          if (len == LT + 1) begin
            e_long = 1'b1;
            if (n == 3) e_short = 1'b1;
          end
          if (REP_ON && len > LT + 1 && (len - LT - 1) % RT == 0) e_rep = 1'b1;
        end
        2, 4: begin
          if (runs[n-2] > LT) begin
            end_episode();
          end else if (n == 4) begin
            e_dbl = 1'b1;
            end_episode();
          end else if (len == DT + 1) begin
            e_short = 1'b1;
            end_episode();
          end
        end
        default: end_episode();
      endcase
    end
    e_busy = m_active;
    e_held = m_active && (runs.size() % 2 == 1) && (runs[runs.size()-1] > LT);
  endtask

  task automatic chk(input string tag, input logic got, input logic exp);
    n_checks++;
    assert (got === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s got=%0b exp=%0b", tag, got, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int got, input int exp);
    n_checks++;
    assert (got == exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // driver: one clock with the given inputs, then compare every output
  task automatic step(input bit r, input bit e, input bit iv);
    @(negedge clk);
    rst = r;
    en  = e;
    i   = iv;
    @(posedge clk);
    model_edge(r, e, iv);
    #1;
    chk("short_p", short_p, e_short);
    chk("long_p",  long_p,  e_long);
    chk("dbl_p",   dbl_p,   e_dbl);
    chk("rep_p",   rep_p,   e_rep);
    chk("held",    held,    e_held);
    chk("busy",    busy,    e_busy);
    t_short += int'(short_p);
    t_long  += int'(long_p);
    t_dbl   += int'(dbl_p);
    t_rep   += int'(rep_p);
  endtask

  task automatic clear_tally();
    t_short = 0;
    t_long  = 0;
    t_dbl   = 0;
    t_rep   = 0;
  endtask

  task automatic run_level(input bit iv, input int len);
    for (int k = 0; k < len; k++) step(1'b0, 1'b1, iv);
  endtask

  initial begin
    bit lvl;
    int len;
    clear_tally();

    // reset state
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1);
    chk("reset_busy", busy, 1'b0);
    chk("reset_held", held, 1'b0);

    // short press: 2 high, release; short after 4th low
    clear_tally();
    run_level(1'b1, 2);
    run_level(1'b0, 3);
    chk("s1_pre_short", short_p, 1'b0);
    run_level(1'b0, 1);
    chk("s1_short_now", short_p, 1'b1);
    chk("s1_busy_fall", busy, 1'b0);
    run_level(1'b0, 3);
    chk_int("s1_short_cnt", t_short, 1);
    chk_int("s1_long_cnt", t_long, 0);
    chk_int("s1_dbl_cnt", t_dbl, 0);

    // long press then release
    clear_tally();
    run_level(1'b1, 6);
    chk("s2_long_now", long_p, 1'b1);
    chk("s2_held", held, 1'b1);
    run_level(1'b0, 4);
    chk("s2_held_fall", held, 1'b0);
    chk_int("s2_long_cnt", t_long, 1);
    chk_int("s2_short_cnt", t_short, 0);

    // double press
    clear_tally();
    run_level(1'b1, 2);
    run_level(1'b0, 2);
    run_level(1'b1, 2);
    run_level(1'b0, 1);
    chk("s3_dbl_now", dbl_p, 1'b1);
    run_level(1'b0, 5);
    chk_int("s3_dbl_cnt", t_dbl, 1);
    chk_int("s3_short_cnt", t_short, 0);

    // short press with en toggling: same result, twice the time
    clear_tally();
    for (int k = 0; k < 2; k++) begin step(1'b0, 1'b1, 1'b1); step(1'b0, 1'b0, 1'b1); end
    for (int k = 0; k < 5; k++) begin step(1'b0, 1'b1, 1'b0); step(1'b0, 1'b0, 1'b0); end
    chk_int("s4_short_cnt", t_short, 1);
    chk_int("s4_long_cnt", t_long, 0);

    // reset mid-press with i held high
    clear_tally();
    run_level(1'b1, 3);
    step(1'b1, 1'b1, 1'b1);
    chk("s5_rst_busy", busy, 1'b0);
    run_level(1'b1, 5);
    chk("s5_long_early", long_p, 1'b0);
    run_level(1'b1, 1);
    chk("s5_long_now", long_p, 1'b1);
    run_level(1'b0, 2);
    chk_int("s5_long_cnt", t_long, 1);

    // long hold for auto-repeat
    clear_tally();
    run_level(1'b1, 10);
    run_level(1'b0, 2);
    chk_int("s6_long_cnt", t_long, 1);
    chk_int("s6_rep_cnt", t_rep, REP_ON ? 2 : 0);

    // second press going long: short and long together
    clear_tally();
    run_level(1'b1, 1);
    run_level(1'b0, 1);
    run_level(1'b1, 6);
    chk("s7_short_now", short_p, 1'b1);
    chk("s7_long_now", long_p, 1'b1);
    run_level(1'b0, 2);

    // randomized key traffic with random en gaps and rare resets
    lvl = 1'b0;
    for (int k = 0; k < 600; k++) begin
      lvl = ~lvl;
      len = $urandom_range(1, 9);
      for (int j = 0; j < len; j++) begin
        step(($urandom_range(0, 299) == 0), ($urandom_range(0, 3) != 0), lvl);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
